// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared types and constants for the Sobel frame controller: FSM states,
// tag field widths, the pixel tag record and the frame-size check.
package sobel_frame_ctrl_pkg;

  // Width of the width/height inputs and of the row/col tag fields
  localparam int DIM_W = 16;
  localparam int ROW_W = 16;
  localparam int COL_W = 16;

  // Smallest legal frame dimension: the 3x3 Sobel window needs two
  // border rows/cols before the first result exists
  localparam int MIN_DIM = 3;

  // Default upper bound on accepted frame width
  localparam int DEF_MAX_WIDTH = 1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Tag carried alongside each pixel from ROM read to result write
  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tag_t;

  // True when the frame cannot be processed: too small for the window,
  // wider than the line buffers, or larger than the address space
  function automatic logic size_bad(input logic [DIM_W-1:0] w,
                                    input logic [DIM_W-1:0] h,
                                    input int unsigned      max_w,
                                    input int unsigned      addr_w);
    logic [31:0] prod;
    logic [32:0] limit;
    prod  = 32'(w) * 32'(h);
    limit = 33'(1) << addr_w;
    return (w < DIM_W'(MIN_DIM)) ||
           (h < DIM_W'(MIN_DIM)) ||
           (32'(w) > max_w)      ||
           ({1'b0, prod} > limit);
  endfunction

endpackage

// File: rtl/sobel_tag_pipe.sv
// Fixed-depth shift register for the {valid,row,col} pixel tags. Stage k
// (0-based) holds the tag of the read issued k+1 cycles ago. Exposes the
// valid bits of every stage but the last, the column at the engine-input
// tap, and the complete final-stage tag.
module sobel_tag_pipe
  import sobel_frame_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int TAP   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  tag_t             tag_i,
  output logic [DEPTH-2:0] valid_o,
  output logic [COL_W-1:0] tap_col_o,
  output tag_t             last_o
);

  tag_t pipe_q [DEPTH];

  // Advance every tag one stage per cycle; reset empties the pipe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Gather the occupancy of all stages that still feed another stage
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < DEPTH - 1; i++) valid_o[i] = pipe_q[i].valid;
  end

  assign tap_col_o = pipe_q[TAP].col;
  assign last_o    = pipe_q[DEPTH-1];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel edge datapath. Validates the frame size,
// issues raster-order ROM reads (pausable with stall), tracks each pixel
// through ROM and engine latency with a tag pipe, and writes the interior
// results to the result RAM at a dense address.
module sobel_frame_ctrl
  import sobel_frame_ctrl_pkg::*;
#(
  parameter int MAX_WIDTH = DEF_MAX_WIDTH,
  parameter int ADDR_W    = 20,
  parameter int ROM_LAT   = 1,
  parameter int SOBEL_LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [15:0]        width_i,
  input  logic [15:0]        height_i,
  input  logic               stall_i,
  output logic               rom_en_o,
  output logic [ADDR_W-1:0]  rom_addr_o,
  output logic               pix_valid_o,
  output logic               row_start_o,
  input  logic signed [15:0] edge_in_i,
  output logic               res_we_o,
  output logic [ADDR_W-1:0]  res_addr_o,
  output logic signed [15:0] res_wdata_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int DEPTH = ROM_LAT + SOBEL_LAT;

  state_e            state_q;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] res_addr_q;
  logic              busy_q, done_q, err_q;

  logic              issue;
  logic              last_read;
  logic              drain_empty;
  logic              res_we;
  tag_t              issue_tag;
  tag_t              last_tag;
  logic [DEPTH-2:0]  stage_valid;
  logic [COL_W-1:0]  tap_col;

  assign issue     = (state_q == ST_RUN) && !stall_i;
  assign last_read = issue &&
                     (row_q == height_q - DIM_W'(1)) &&
                     (col_q == width_q - DIM_W'(1));

  // Raster scan position after the current read: col wraps into the next row
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (issue) begin
      if (col_q == width_q - DIM_W'(1)) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Tag for the read going out this cycle; idle cycles push an empty tag
  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = issue;
    issue_tag.row   = row_q;
    issue_tag.col   = col_q;
  end

  sobel_tag_pipe #(
    .DEPTH (DEPTH),
    .TAP   (ROM_LAT - 1)
  ) u_tag_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tag_i     (issue_tag),
    .valid_o   (stage_valid),
    .tap_col_o (tap_col),
    .last_o    (last_tag)
  );

  // The frame is finished once only the final stage can still hold a pixel
  assign drain_empty = ~|stage_valid;

  // Border pixels feed the window but produce no result of their own
  assign res_we = last_tag.valid &&
                  (last_tag.row >= ROW_W'(2)) &&
                  (last_tag.col >= COL_W'(2));

  // Frame FSM: latches the size, owns the scan counters and status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      height_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_CHECK;
            width_q   <= width_i;
            height_q  <= height_i;
            row_q     <= '0;
            col_q     <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (size_bad(width_q, height_q, MAX_WIDTH, ADDR_W)) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            row_q     <= row_d;
            col_q     <= col_d;
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
          if (last_read) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_empty) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Dense result address: one step per written result, restarted per frame
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_addr_q <= '0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      res_addr_q <= '0;
    end else if (res_we) begin
      res_addr_q <= res_addr_q + ADDR_W'(1);
    end
  end

  assign rom_en_o    = issue;
  assign rom_addr_o  = rd_addr_q;
  assign pix_valid_o = stage_valid[ROM_LAT-1];
  assign row_start_o = stage_valid[ROM_LAT-1] && (tap_col == '0);
  assign res_we_o    = res_we;
  assign res_addr_o  = res_addr_q;
  assign res_wdata_o = edge_in_i;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
